// File: rtl/algo_nrnw_fwd_top_wrap_if.sv
// Bus bundle for the N-read/M-write forwarding wrapper: user-side ports plus
// the physical t1 SRAM ports. The design takes the slave view.
interface algo_nrnw_fwd_top_wrap_if #(
  parameter int NUMRDPRT = 2,
  parameter int NUMWRPRT = 2,
  parameter int WIDTH    = 15,
  parameter int BITADDR  = 8,
  parameter int CNTWIDTH = 8
);
  logic                         flopout_en;
  logic [NUMRDPRT-1:0]          read;
  logic [NUMRDPRT*BITADDR-1:0]  rd_adr;
  logic [NUMRDPRT*WIDTH-1:0]    rd_dout;
  logic [NUMRDPRT-1:0]          rd_vld;
  logic [NUMWRPRT-1:0]          write;
  logic [NUMWRPRT*BITADDR-1:0]  wr_adr;
  logic [NUMWRPRT*WIDTH-1:0]    din;
  logic [NUMWRPRT*WIDTH-1:0]    bw;
  logic [NUMRDPRT-1:0]          t1_read;
  logic [NUMRDPRT*BITADDR-1:0]  t1_rd_adr;
  logic [NUMRDPRT*WIDTH-1:0]    t1_dout;
  logic [NUMWRPRT-1:0]          t1_write;
  logic [NUMWRPRT*BITADDR-1:0]  t1_wr_adr;
  logic [NUMWRPRT*WIDTH-1:0]    t1_din;
  logic [NUMWRPRT*WIDTH-1:0]    t1_bw;
  logic [CNTWIDTH-1:0]          coll_cnt;

  modport master (
    output flopout_en, read, rd_adr, write, wr_adr, din, bw, t1_dout,
    input  rd_dout, rd_vld, t1_read, t1_rd_adr, t1_write, t1_wr_adr, t1_din, t1_bw, coll_cnt
  );

  modport slave (
    input  flopout_en, read, rd_adr, write, wr_adr, din, bw, t1_dout,
    output rd_dout, rd_vld, t1_read, t1_rd_adr, t1_write, t1_wr_adr, t1_din, t1_bw, coll_cnt
  );
endinterface

// File: rtl/algo_nrnw_fwd_top_wrap.sv
// N-read/M-write memory wrapper: per-bit write arbitration (highest port wins),
// same-cycle write-to-read forwarding over a read-first SRAM, gated output stages.
module algo_nrnw_fwd_top_wrap #(
  parameter int NUMRDPRT = 2,
  parameter int NUMWRPRT = 2,
  parameter int WIDTH    = 15,
  parameter int NUMADDR  = 256,
  parameter int BITADDR  = 8,
  parameter int T1_DELAY = 1,
  parameter int FLOPOUT  = 0,
  parameter int CNTWIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  algo_nrnw_fwd_top_wrap_if.slave bus
);
  localparam int ADRW = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;
  localparam int CMPW = (ADRW < BITADDR) ? ADRW : BITADDR;

  function automatic logic adr_eq(input logic [BITADDR-1:0] a, input logic [BITADDR-1:0] b);
    return a[CMPW-1:0] == b[CMPW-1:0];
  endfunction

  logic [NUMWRPRT*WIDTH-1:0] t1_bw_c;
  logic                      coll_c;
  logic [NUMRDPRT*WIDTH-1:0] mask_s0, fdat_s0;
  logic [NUMRDPRT-1:0]       rv_ret;
  logic [NUMRDPRT*WIDTH-1:0] mask_ret, fdat_ret, data_ret;
  logic [CNTWIDTH-1:0]       coll_q;

  assign bus.t1_read   = bus.read;
  assign bus.t1_rd_adr = bus.rd_adr;
  assign bus.t1_write  = bus.write;
  assign bus.t1_wr_adr = bus.wr_adr;
  assign bus.t1_din    = bus.din;
  assign bus.t1_bw     = t1_bw_c;
  assign bus.coll_cnt  = coll_q;

  always_comb begin
    t1_bw_c = '0;
    coll_c  = 1'b0;
    mask_s0 = '0;
    fdat_s0 = '0;
    for (int unsigned j = 0; j < NUMWRPRT; j++) begin
      t1_bw_c[j*WIDTH +: WIDTH] = bus.bw[j*WIDTH +: WIDTH];
      for (int unsigned k = j + 1; k < NUMWRPRT; k++) begin
        if (bus.write[k] && adr_eq(bus.wr_adr[k*BITADDR +: BITADDR], bus.wr_adr[j*BITADDR +: BITADDR])) begin
          t1_bw_c[j*WIDTH +: WIDTH] &= ~bus.bw[k*WIDTH +: WIDTH];
          if (bus.write[j] && |(bus.bw[j*WIDTH +: WIDTH] & bus.bw[k*WIDTH +: WIDTH]))
            coll_c = 1'b1;
        end
      end
    end
    // Arbitrated enables never overlap, so forwarded data can be OR-combined.
    for (int unsigned i = 0; i < NUMRDPRT; i++) begin
      for (int unsigned j = 0; j < NUMWRPRT; j++) begin
        if (bus.write[j] && adr_eq(bus.wr_adr[j*BITADDR +: BITADDR], bus.rd_adr[i*BITADDR +: BITADDR])) begin
          mask_s0[i*WIDTH +: WIDTH] |= t1_bw_c[j*WIDTH +: WIDTH];
          fdat_s0[i*WIDTH +: WIDTH] |= bus.din[j*WIDTH +: WIDTH] & t1_bw_c[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          coll_q <= '0;
    else if (coll_c && (coll_q != '1)) coll_q <= coll_q + 1'b1;
  end

  generate
    if (T1_DELAY == 0) begin : g_nodly
      assign rv_ret   = bus.read & {NUMRDPRT{rst}};
      assign mask_ret = mask_s0;
      assign fdat_ret = fdat_s0;
    end else begin : g_dly
      logic [NUMRDPRT-1:0]       rv_q   [T1_DELAY];
      logic [NUMRDPRT*WIDTH-1:0] mask_q [T1_DELAY];
      logic [NUMRDPRT*WIDTH-1:0] fdat_q [T1_DELAY];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned s = 0; s < T1_DELAY; s++) begin
            rv_q[s]   <= '0;
            mask_q[s] <= '0;
            fdat_q[s] <= '0;
          end
        end else begin
          rv_q[0]   <= bus.read;
          mask_q[0] <= mask_s0;
          fdat_q[0] <= fdat_s0;
          for (int unsigned s = 1; s < T1_DELAY; s++) begin
            rv_q[s]   <= rv_q[s-1];
            mask_q[s] <= mask_q[s-1];
            fdat_q[s] <= fdat_q[s-1];
          end
        end
      end
      assign rv_ret   = rv_q[T1_DELAY-1];
      assign mask_ret = mask_q[T1_DELAY-1];
      assign fdat_ret = fdat_q[T1_DELAY-1];
    end
  endgenerate

  assign data_ret = (bus.t1_dout & ~mask_ret) | (fdat_ret & mask_ret);

  generate
    if (FLOPOUT == 0) begin : g_noflop
      logic [NUMRDPRT*WIDTH-1:0] hold_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= '0;
        else
          for (int unsigned i = 0; i < NUMRDPRT; i++)
            if (rv_ret[i]) hold_q[i*WIDTH +: WIDTH] <= data_ret[i*WIDTH +: WIDTH];
      end
      always_comb begin
        bus.rd_dout = hold_q;
        for (int unsigned i = 0; i < NUMRDPRT; i++)
          if (rv_ret[i]) bus.rd_dout[i*WIDTH +: WIDTH] = data_ret[i*WIDTH +: WIDTH];
      end
      assign bus.rd_vld = rv_ret;
    end else begin : g_flop
      // One landing slot catches SRAM returns while the output stages are
      // stalled; a second return before the stages advance overwrites it.
      logic [NUMRDPRT-1:0]       land_v_q;
      logic [NUMRDPRT*WIDTH-1:0] land_d_q;
      logic [NUMRDPRT-1:0]       ov_q [FLOPOUT];
      logic [NUMRDPRT*WIDTH-1:0] od_q [FLOPOUT];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          land_v_q <= '0;
          land_d_q <= '0;
          for (int unsigned s = 0; s < FLOPOUT; s++) begin
            ov_q[s] <= '0;
            od_q[s] <= '0;
          end
        end else if (bus.flopout_en) begin
          land_v_q <= '0;
          for (int unsigned i = 0; i < NUMRDPRT; i++) begin
            ov_q[0][i] <= land_v_q[i] | rv_ret[i];
            if (land_v_q[i])    od_q[0][i*WIDTH +: WIDTH] <= land_d_q[i*WIDTH +: WIDTH];
            else if (rv_ret[i]) od_q[0][i*WIDTH +: WIDTH] <= data_ret[i*WIDTH +: WIDTH];
          end
          for (int unsigned s = 1; s < FLOPOUT; s++)
            for (int unsigned i = 0; i < NUMRDPRT; i++) begin
              ov_q[s][i] <= ov_q[s-1][i];
              if (ov_q[s-1][i]) od_q[s][i*WIDTH +: WIDTH] <= od_q[s-1][i*WIDTH +: WIDTH];
            end
        end else begin
          for (int unsigned i = 0; i < NUMRDPRT; i++)
            if (rv_ret[i]) begin
              land_v_q[i]                 <= 1'b1;
              land_d_q[i*WIDTH +: WIDTH]  <= data_ret[i*WIDTH +: WIDTH];
            end
        end
      end
      assign bus.rd_vld  = ov_q[FLOPOUT-1];
      assign bus.rd_dout = od_q[FLOPOUT-1];
    end
  endgenerate
endmodule

// File: tb/tb_algo_nrnw_fwd_top_wrap.sv
// Scoreboard bench: dut0 uses the default configuration, dut1 has FLOPOUT=1 and
// a 2-bit collision counter. Each DUT is backed by a read-first SRAM model.
module tb_algo_nrnw_fwd_top_wrap;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        en1_prev;
  logic [14:0] mem0 [256];
  logic [14:0] mem1 [256];
  int          sat_exp [5] = '{1, 2, 3, 3, 3};

  algo_nrnw_fwd_top_wrap_if #(.NUMRDPRT(2), .NUMWRPRT(2), .WIDTH(15), .BITADDR(8), .CNTWIDTH(8)) b0 ();
  algo_nrnw_fwd_top_wrap_if #(.NUMRDPRT(2), .NUMWRPRT(2), .WIDTH(15), .BITADDR(8), .CNTWIDTH(2)) b1 ();

  algo_nrnw_fwd_top_wrap #(.NUMRDPRT(2), .NUMWRPRT(2), .WIDTH(15), .NUMADDR(256), .BITADDR(8),
                           .T1_DELAY(1), .FLOPOUT(0), .CNTWIDTH(8))
    u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  algo_nrnw_fwd_top_wrap #(.NUMRDPRT(2), .NUMWRPRT(2), .WIDTH(15), .NUMADDR(256), .BITADDR(8),
                           .T1_DELAY(1), .FLOPOUT(1), .CNTWIDTH(2))
    u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  function automatic logic [14:0] mem_upd(input logic [14:0] old, input logic [7:0] a,
                                          input logic [1:0] we, input logic [15:0] wa,
                                          input logic [29:0] wd, input logic [29:0] wb);
    logic [14:0] w;
    w = old;
    for (int k = 0; k < 2; k++)
      if (we[k] && wa[k*8 +: 8] == a) w = (w & ~wb[k*15 +: 15]) | (wd[k*15 +: 15] & wb[k*15 +: 15]);
    return w;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) b0.t1_dout[i*15 +: 15] <= mem0[b0.t1_rd_adr[i*8 +: 8]];
    for (int j = 0; j < 2; j++)
      if (b0.t1_write[j])
        mem0[b0.t1_wr_adr[j*8 +: 8]] <= mem_upd(mem0[b0.t1_wr_adr[j*8 +: 8]], b0.t1_wr_adr[j*8 +: 8],
                                                b0.t1_write, b0.t1_wr_adr, b0.t1_din, b0.t1_bw);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) b1.t1_dout[i*15 +: 15] <= mem1[b1.t1_rd_adr[i*8 +: 8]];
    for (int j = 0; j < 2; j++)
      if (b1.t1_write[j])
        mem1[b1.t1_wr_adr[j*8 +: 8]] <= mem_upd(mem1[b1.t1_wr_adr[j*8 +: 8]], b1.t1_wr_adr[j*8 +: 8],
                                                b1.t1_write, b1.t1_wr_adr, b1.t1_din, b1.t1_bw);
  end

  always @(posedge clk) en1_prev <= b1.flopout_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int d, input int p, input logic [14:0] act);
    logic [15:0] e;
    int n;
    n = (d == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL d%0d_unexpected_vld port=%0d got=%h want=none t=%0t", d, p, act, $time);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("d%0d_rd_port", d), 32'(p), 32'(e[15]));
      chk($sformatf("d%0d_rd_dout", d), 32'(act), 32'(e[14:0]));
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        if (b0.rd_vld[i]) mon(0, i, b0.rd_dout[i*15 +: 15]);
        if (b1.rd_vld[i] && en1_prev) mon(1, i, b1.rd_dout[i*15 +: 15]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [1:0] w, input logic [7:0] a0, input logic [7:0] a1,
                    input logic [14:0] d0v, input logic [14:0] d1v,
                    input logic [14:0] bw0, input logic [14:0] bw1);
    if (d == 0) begin
      b0.write = w; b0.wr_adr = {a1, a0}; b0.din = {d1v, d0v}; b0.bw = {bw1, bw0};
    end else begin
      b1.write = w; b1.wr_adr = {a1, a0}; b1.din = {d1v, d0v}; b1.bw = {bw1, bw0};
    end
  endtask

  task automatic rd(input int d, input logic [1:0] r, input logic [7:0] a0, input logic [7:0] a1);
    if (d == 0) begin b0.read = r; b0.rd_adr = {a1, a0}; end
    else        begin b1.read = r; b1.rd_adr = {a1, a0}; end
  endtask

  task automatic idle(input int d);
    rd(d, 2'b00, 8'h00, 8'h00);
    wr(d, 2'b00, 8'h00, 8'h00, 15'h0, 15'h0, 15'h0, 15'h0);
  endtask

  initial begin
    rst = 1'b0;
    idle(0); idle(1);
    b0.flopout_en = 1'b0;
    b1.flopout_en = 1'b1;

    // reset with reads and colliding writes active
    rd(0, 2'b11, 8'h01, 8'h02); rd(1, 2'b11, 8'h01, 8'h02);
    wr(0, 2'b11, 8'hEE, 8'hEE, 15'h1, 15'h2, 15'h7FFF, 15'h7FFF);
    wr(1, 2'b11, 8'hEE, 8'hEE, 15'h1, 15'h2, 15'h7FFF, 15'h7FFF);
    tick; tick; #1;
    chk("rst_d0_vld",  32'(b0.rd_vld),   32'(2'b00));
    chk("rst_d0_dout", 32'(b0.rd_dout),  32'(30'h0));
    chk("rst_d0_coll", 32'(b0.coll_cnt), 32'(8'h0));
    chk("rst_d1_vld",  32'(b1.rd_vld),   32'(2'b00));
    chk("rst_d1_dout", 32'(b1.rd_dout),  32'(30'h0));
    chk("rst_d1_coll", 32'(b1.coll_cnt), 32'(2'h0));
    idle(0); idle(1);
    tick; rst = 1'b1;
    repeat (4) begin
      tick; #1;
      chk("idle_d0_vld", 32'(b0.rd_vld), 32'(2'b00));
      chk("idle_d1_vld", 32'(b1.rd_vld), 32'(2'b00));
    end

    // preload mem0[20]=0, mem0[30]=0
    wr(0, 2'b11, 8'h20, 8'h30, 15'h0, 15'h0, 15'h7FFF, 15'h7FFF);
    tick; idle(0);

    // basic write then read on the other port
    wr(0, 2'b01, 8'h10, 8'h00, 15'h1234, 15'h0, 15'h7FFF, 15'h0);
    tick; idle(0);
    rd(0, 2'b10, 8'h00, 8'h10); q0.push_back({1'b1, 15'h1234});
    tick; idle(0); #1;
    chk("basic_vld", 32'(b0.rd_vld), 32'(2'b10));

    // overlapping collision
    wr(0, 2'b11, 8'h20, 8'h20, 15'h7FFF, 15'h0000, 15'h00FF, 15'h0F0F);
    #1;
    chk("coll_t1_bw0", 32'(b0.t1_bw[14:0]),  32'(15'h00F0));
    chk("coll_t1_bw1", 32'(b0.t1_bw[29:15]), 32'(15'h0F0F));
    tick; idle(0); #1;
    chk("coll_cnt1", 32'(b0.coll_cnt), 32'(8'd1));
    rd(0, 2'b01, 8'h20, 8'h00); q0.push_back({1'b0, 15'h00F0});
    tick; idle(0);

    // same address, disjoint enables: no collision
    wr(0, 2'b11, 8'h40, 8'h40, 15'h1234, 15'h7A00, 15'h00FF, 15'h7F00);
    #1;
    chk("nocoll_t1_bw0", 32'(b0.t1_bw[14:0]), 32'(15'h00FF));
    tick; idle(0); #1;
    chk("nocoll_cnt", 32'(b0.coll_cnt), 32'(8'd1));
    rd(0, 2'b10, 8'h00, 8'h40); q0.push_back({1'b1, 15'h7A34});
    tick; idle(0);

    // same-cycle forwarding to both read ports
    rd(0, 2'b11, 8'h30, 8'h30);
    wr(0, 2'b10, 8'h00, 8'h30, 15'h0, 15'h5555, 15'h0, 15'h00FF);
    q0.push_back({1'b0, 15'h0055}); q0.push_back({1'b1, 15'h0055});
    tick; idle(0);
    rd(0, 2'b01, 8'h30, 8'h00); q0.push_back({1'b0, 15'h0055});
    tick; idle(0);
    wr(0, 2'b01, 8'h30, 8'h00, 15'h7FFF, 15'h0, 15'h7FFF, 15'h0);
    tick; idle(0);
    rd(0, 2'b01, 8'h30, 8'h00); q0.push_back({1'b0, 15'h7FFF});
    tick; idle(0);
    tick;

    // saturation on the 2-bit counter
    wr(1, 2'b11, 8'h50, 8'h50, 15'h1, 15'h2, 15'h0001, 15'h0001);
    for (int n = 0; n < 5; n++) begin
      tick; #1;
      chk($sformatf("sat_cnt%0d", n), 32'(b1.coll_cnt), 32'(sat_exp[n]));
    end
    idle(1);

    // dut1 latency with flopout_en held high
    wr(1, 2'b01, 8'h60, 8'h00, 15'h2A5C, 15'h0, 15'h7FFF, 15'h0);
    tick; idle(1);
    rd(1, 2'b10, 8'h00, 8'h60); q1.push_back({1'b1, 15'h2A5C});
    tick; idle(1); #1;
    chk("fo_lat_c1", 32'(b1.rd_vld), 32'(2'b00));
    tick; #1;
    chk("fo_lat_c2", 32'(b1.rd_vld), 32'(2'b10));
    tick; tick;

    // output stage stalled for cycles 1-3, advanced in cycle 4
    b1.flopout_en = 1'b0;
    rd(1, 2'b01, 8'h60, 8'h00); q1.push_back({1'b0, 15'h2A5C});
    for (int c = 1; c <= 4; c++) begin
      tick; idle(1);
      if (c == 4) b1.flopout_en = 1'b1;
      #1;
      chk($sformatf("gate_c%0d", c), 32'(b1.rd_vld), 32'(2'b00));
    end
    tick; #1;
    chk("gate_c5", 32'(b1.rd_vld), 32'(2'b01));
    tick; #1;
    chk("gate_c6", 32'(b1.rd_vld), 32'(2'b00));

    // repeat run with a reset pulse while the read is parked
    b1.flopout_en = 1'b0;
    rd(1, 2'b01, 8'h60, 8'h00);
    tick; idle(1);
    tick; rst = 1'b0; #1;
    chk("rpt_rst_vld",  32'(b1.rd_vld),   32'(2'b00));
    chk("rpt_rst_coll", 32'(b1.coll_cnt), 32'(2'h0));
    tick; rst = 1'b1;
    tick; b1.flopout_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick; #1;
      chk($sformatf("rpt_vld%0d", c), 32'(b1.rd_vld), 32'(2'b00));
    end

    repeat (3) tick;
    chk("d0_pending", 32'(q0.size()), 32'(0));
    chk("d1_pending", 32'(q1.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/algo_nrnw_fwd_top_wrap.md
Name: algo_nrnw_fwd_top_wrap

Overview:
- Parametrised N-read/M-write memory wrapper; successor to the fixed 2r2w pass-through wrapper.
- Maps NUMRDPRT read ports and NUMWRPRT write ports onto the same number of physical t1 ports.
- Adds behaviour the pass-through does not have: per-bit write-collision arbitration, same-cycle write-to-read forwarding, a delay-matched valid/data pipeline with gated output flops, and a saturating collision counter.
- Sits between the IP top-level ports and the physical multiport SRAM macro.

Parameters:
NUMRDPRT, 2, number of read ports (1..4)
NUMWRPRT, 2, number of write ports (1..4)
WIDTH, 15, data width in bits
NUMADDR, 256, number of addressable words
BITADDR, 8, address width, clog2(NUMADDR)
T1_DELAY, 1, SRAM read latency in cycles (0..4)
FLOPOUT, 0, extra output register stages (0..2)
CNTWIDTH, 8, collision counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
flopout_en  in  1  advance enable for FLOPOUT stages
read  in  NUMRDPRT  per-port read request
rd_adr  in  NUMRDPRT*BITADDR  read addresses, port i at [i*BITADDR +: BITADDR]
rd_dout  out  NUMRDPRT*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
rd_vld  out  NUMRDPRT  read data valid
write  in  NUMWRPRT  per-port write request
wr_adr  in  NUMWRPRT*BITADDR  write addresses
din  in  NUMWRPRT*WIDTH  write data
bw  in  NUMWRPRT*WIDTH  per-bit write enables
t1_read  out  NUMRDPRT  physical read enables
t1_rd_adr  out  NUMRDPRT*BITADDR  physical read addresses
t1_dout  in  NUMRDPRT*WIDTH  physical read data, valid T1_DELAY cycles after t1_read
t1_write  out  NUMWRPRT  physical write enables
t1_wr_adr  out  NUMWRPRT*BITADDR  physical write addresses
t1_din  out  NUMWRPRT*WIDTH  physical write data
t1_bw  out  NUMWRPRT*WIDTH  arbitrated physical bit enables
coll_cnt  out  CNTWIDTH  saturating write-collision count

Behaviour:
- Reset:
  - rst=0 asynchronously clears all pipeline valids, the forwarding pipeline, output registers and coll_cnt.
  - rd_vld=0, rd_dout=0 and coll_cnt=0 while rst=0.
  - Reset mid-operation drops all in-flight reads; no rd_vld ever appears for reads issued before reset.
- Read issue (combinational, no added latency):
  - t1_read[i] = read[i]; t1_rd_adr = rd_adr.
- Write path (combinational):
  - t1_write, t1_wr_adr and t1_din pass through.
  - t1_bw[j] = bw[j] with every bit cleared that is also enabled by a higher-index port k>j having write[k]=1 and wr_adr[k]==wr_adr[j].
  - Result: the highest-index port wins per bit; non-overlapping bits from all ports are written.
  - A port with write=0 contributes no enables; its t1_write=0 and t1_bw are don't-care.
- Collision counter:
  - Increments by 1 per cycle in which any pair of ports j<k has write[j]=write[k]=1, equal addresses, and overlapping bw.
  - Maximum increment is 1 per cycle regardless of how many pairs collide.
  - Saturates at 2^CNTWIDTH-1; never wraps.
- Forwarding:
  - The SRAM is read-first (returns old data on a same-cycle read/write to one address).
  - For read port i at issue: mask_i = OR over write ports j with write[j]=1 and wr_adr[j]==rd_adr[i] of the arbitrated t1_bw[j].
  - fdata_i = the corresponding din bits; non-overlapping after arbitration, so OR-combine.
  - (mask_i, fdata_i) are delayed T1_DELAY cycles alongside read[i].
  - On return: data_i = (t1_dout_i & ~mask_i) | (fdata_i & mask_i).
  - Writes issued after the read cycle never affect that read.
  - With T1_DELAY=0 the merge is purely combinational.
- Latency:
  - rd_vld[i] asserts T1_DELAY+FLOPOUT cycles after read[i] when FLOPOUT=0.
  - When FLOPOUT>0, latency is T1_DELAY plus the number of flopout_en=1 cycles needed to traverse the FLOPOUT stages.
  - rd_dout is undefined when rd_vld=0 and is held, not zeroed.
- flopout_en:
  - Gates only the FLOPOUT stages. When 0, those stages (data and valid) hold their value.
  - The T1_DELAY stages always advance. The user must not rely on back-pressure there; data is lost if the output stages stall while SRAM data returns. This is documented, not detected.
  - Ignored when FLOPOUT=0.
- Simultaneous read and write on the same port index or address are fully legal. Reads on multiple ports to the same address each receive independent, identical results.

Test Plan:
- Reset: hold rst=0 with read=2'b11 active -> rd_vld=0, rd_dout=0, coll_cnt=0; release, idle 4 cycles -> rd_vld stays 0.
- Basic (T1_DELAY=1, FLOPOUT=0): write adr 8'h10 din 15'h1234 bw all-ones on port 0; next cycle read port 1 adr 8'h10 -> one cycle later rd_vld=2'b10, rd_dout[29:15]=15'h1234.
- Collision: port 0 writes adr 8'h20 din 15'h7FFF bw 15'h00FF; port 1 writes adr 8'h20 din 15'h0000 bw 15'h0F0F, same cycle:
  - t1_bw port0 = 15'h00F0; t1_bw port1 = 15'h0F0F.
  - Stored word low byte = 8'hF0; coll_cnt=1.
- Forwarding: mem[8'h30]=15'h0000; same cycle read port 0 adr 8'h30 and write port 1 adr 8'h30 din 15'h5555 bw 15'h00FF -> rd_dout[14:0]=15'h0055 after T1_DELAY.
- Saturation (CNTWIDTH=2): 5 consecutive colliding cycles -> coll_cnt sequence 1,2,3,3,3.
- Output gating (FLOPOUT=1, T1_DELAY=1): read at cycle 0, flopout_en=0 in cycles 1-3, 1 in cycle 4 -> rd_vld rises only after cycle 4 edge, data correct; rst=0 pulse in cycle 2 of a repeat run -> no rd_vld.
